icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache that replaces the single-word direct-mapped icache.
- Sits between the datapath fetch port and the memory controller, with the same signal semantics as the datapath_cache_if and cache_control_if icache modports, flattened to ports.
- Adds multi-word blocks, N-way associativity, round-robin replacement, a sequential multi-word fill FSM and a whole-cache flush.

Parameters:
- CPUID, 0, core index; retained for controller arbitration tagging.
- SETS, 16, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, at least 1.
- WORDS, 2, 32-bit words per block; power of 2, at least 1.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  instruction word; valid when ihit=1.
- flush  in  1  invalidate all lines; synchronous, single-cycle pulse.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.

Behaviour:
- Reset and clock: reset nRST, asynchronous, active-low; clock CLK.
- Address split:
  - [1:0] byte offset.
  - WOFF = log2(WORDS) word-offset bits.
  - IDX = log2(SETS) index bits.
  - Tag = remaining 30-WOFF-IDX bits.
- Storage: per way and set: valid, tag, WORDS data words. Per set: round-robin victim pointer, log2(WAYS) bits.
- Reset values: all valid=0; all victim pointers=0; state=IDLE; fill counter=0. Outputs ihit=0, iREN=0, iaddr=0, imemload=0.
- Lookup (combinational):
  - hit = (state==IDLE) & imemREN & any way in set IDX with valid & tag match.
  - ihit = hit.
  - imemload = matching word when hit, else 0.
  - ihit is never asserted in FILL, even for a different address.
- FSM, IDLE:
  - If flush: clear every valid bit; stay in IDLE. Flush takes priority over a miss.
  - Else if imemREN & ~hit: latch block base (imemaddr with word offset and byte offset zeroed), index and tag. Choose victim = lowest-numbered invalid way in the set, else the set's victim pointer. Clear fill counter. Go to FILL.
- FSM, FILL:
  - iREN=1; iaddr = base + 4*counter.
  - On iwait=0: write iload into victim word[counter] and increment counter.
  - On the last word (counter==WORDS-1 and iwait=0): write tag, set valid. Advance the victim pointer to (victim+1) mod WAYS only if the victim was the pointer's way; invalid-way fills do not move it. Go to IDLE.
  - The hit is visible the cycle after the final word (minimum miss latency WORDS+1 cycles with iwait=0).
- Fill-phase boundary conditions:
  - imemaddr changes or imemREN drops during FILL: the fill completes for the latched address. The new address is looked up in IDLE afterwards.
  - flush during FILL: abort immediately. iREN drops next cycle, no valid bit is set, victim pointer is unchanged, all lines are invalidated, state goes to IDLE. Words already written are harmless because valid=0.
  - nRST during FILL: asynchronous return to reset values; iREN deasserts immediately.
  - WORDS=1: FILL lasts exactly one accepted transfer.
  - WAYS=1: victim is always way 0 and the pointer is unused.
- Outside FILL: iREN=0 and iaddr=0.

Test Plan:
- Cold miss (defaults): imemREN=1, imemaddr=0x100, iwait high 2 cycles per word, iload=0xAAAA0001 then 0xAAAA0002. Required: iaddr=0x100 then 0x104; ihit=0 throughout FILL; next cycle ihit=1, imemload=0xAAAA0001. Then imemaddr=0x104 -> ihit=1, imemload=0xAAAA0002, iREN stays 0.
- Conflict/round-robin: fill 0x100 (way0, invalid preference), 0x180 (way1), then 0x100 hit, then 0x200 miss. Required: 0x200 evicts way0 (pointer=0). Re-access 0x180 -> hit; re-access 0x100 -> miss.
- Address change mid-fill: miss on 0x300, switch imemaddr to 0x400 after the first word. Required: iaddr still 0x300/0x304. 0x300 line valid afterwards; 0x400 then misses and fills.
- Flush mid-fill: miss on 0x500, pulse flush after word 0 accepted. Required: iREN=0 next cycle, state IDLE. A previously cached 0x100 now misses; 0x500 also misses.
- Reset mid-fill: assert nRST=0 while iREN=1. Required: iREN=0 and ihit=0 asynchronously; after release, all prior addresses miss.
- Parameter sweep: WAYS=1, WORDS=1, SETS=4. Required: addresses 0x0 and 0x10 alternate misses (same set, single way); each miss holds iREN for exactly one accepted transfer.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: multi-word blocks, per-set round-robin
// replacement, sequential block fill from the memory controller, whole-cache flush.
module icache_assoc #(
  parameter int CPUID = 0,
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int WOFF  = $clog2(WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAGW  = 30 - WOFF - IDX;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = (WORDS > 1) ? WOFF : 1;
  localparam logic [31:0] BLK_MASK = 32'(WORDS * 4 - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t state_r, state_next_s;

  logic [SETS-1:0]  valid_r  [WAYS];
  logic [TAGW-1:0]  tags_r   [WAYS][SETS];
  logic [31:0]      data_r   [WAYS][SETS][WORDS];
  logic [WAY_W-1:0] rr_ptr_r [SETS];

  logic [31:0]      fill_base_r;
  logic [IDX-1:0]   fill_idx_r;
  logic [TAGW-1:0]  fill_tag_r;
  logic [WAY_W-1:0] fill_way_r;
  logic [CNT_W-1:0] fill_cnt_r;
  logic             fill_repl_r;

  logic [31:0]      word_addr_s;
  logic [IDX-1:0]   set_s;
  logic [TAGW-1:0]  tag_s;
  logic [CNT_W-1:0] word_sel_s;
  logic             hit_s;
  logic             has_inv_s;
  logic             miss_s;
  logic             last_word_s;
  logic             accept_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] inv_way_s;
  logic [WAY_W-1:0] next_ptr_s;

  assign word_addr_s = imemaddr >> 5'd2;
  assign set_s       = IDX'(word_addr_s >> WOFF);
  assign tag_s       = TAGW'(word_addr_s >> (WOFF + IDX));
  assign word_sel_s  = CNT_W'(word_addr_s & 32'(WORDS - 1));

  // Tag compare across the ways of the addressed set; the descending scan leaves
  // the lowest-numbered invalid way as the fill preference.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    has_inv_s = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = (valid_r[w][set_s] && (tags_r[w][set_s] == tag_s)) ? WAY_W'(w) : hit_way_s;
      hit_s     = hit_s | (valid_r[w][set_s] && (tags_r[w][set_s] == tag_s));
      inv_way_s = (!valid_r[w][set_s]) ? WAY_W'(w) : inv_way_s;
      has_inv_s = has_inv_s | !valid_r[w][set_s];
    end
    hit_s = hit_s & imemREN & (state_r == IDLE);
  end

  assign miss_s      = (state_r == IDLE) & imemREN & ~hit_s;
  assign last_word_s = (fill_cnt_r == CNT_W'(WORDS - 1));
  assign accept_s    = (state_r == FILL) & ~flush & ~iwait;
  assign next_ptr_s  = (WAYS == 1) ? '0 : fill_way_r + WAY_W'(1);

  assign ihit     = hit_s;
  assign imemload = hit_s ? data_r[hit_way_s][set_s][word_sel_s] : 32'h0000_0000;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state and memory-side request decode.
  always_comb begin
    state_next_s = state_r;
    iREN         = 1'b0;
    iaddr        = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (!flush && miss_s) state_next_s = FILL;
        else                  state_next_s = IDLE;
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_base_r + (32'(fill_cnt_r) << 5'd2);
        if (flush || (!iwait && last_word_s)) state_next_s = IDLE;
        else                                  state_next_s = FILL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Valid bits, replacement pointers and the latched fill context.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr_r[s] <= '0;
      fill_base_r <= 32'h0000_0000;
      fill_idx_r  <= '0;
      fill_tag_r  <= '0;
      fill_way_r  <= '0;
      fill_cnt_r  <= '0;
      fill_repl_r <= 1'b0;
    end else if (flush) begin
      for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
    end else if (miss_s) begin
      fill_base_r <= imemaddr & ~BLK_MASK;
      fill_idx_r  <= set_s;
      fill_tag_r  <= tag_s;
      fill_way_r  <= has_inv_s ? inv_way_s : rr_ptr_r[set_s];
      fill_repl_r <= ~has_inv_s;
      fill_cnt_r  <= '0;
    end else if (accept_s) begin
      if (last_word_s) begin
        valid_r[fill_way_r][fill_idx_r] <= 1'b1;
        fill_cnt_r                      <= '0;
        // Only a true replacement (victim taken from the pointer) rotates the set.
        if (fill_repl_r) rr_ptr_r[fill_idx_r] <= next_ptr_s;
      end else begin
        fill_cnt_r <= fill_cnt_r + CNT_W'(1);
      end
    end
  end

  // Tag and data arrays; contents are only meaningful under a set valid bit.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      data_r[fill_way_r][fill_idx_r][fill_cnt_r] <= iload;
      if (last_word_s) tags_r[fill_way_r][fill_idx_r] <= fill_tag_r;
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: default instance plus a WAYS=1/WORDS=1/SETS=4 sweep instance.
module tb_icache_assoc;
  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        flush = 1'b0;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;

  logic        ihit0, iren0, ihit1, iren1;
  logic [31:0] load0, iaddr0, load1, iaddr1;
  logic        ihit_o, iren_o;
  logic [31:0] load_o, iaddr_o;

  bit sel = 1'b0;
  int words = 2;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always #5 CLK = ~CLK;

  icache_assoc dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit0), .imemload(load0), .flush(flush), .iREN(iren0),
    .iaddr(iaddr0), .iwait(iwait), .iload(iload)
  );

  icache_assoc #(.CPUID(1), .SETS(4), .WAYS(1), .WORDS(1)) dut_small (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit1), .imemload(load1), .flush(flush), .iREN(iren1),
    .iaddr(iaddr1), .iwait(iwait), .iload(iload)
  );

  assign ihit_o  = sel ? ihit1  : ihit0;
  assign iren_o  = sel ? iren1  : iren0;
  assign load_o  = sel ? load1  : load0;
  assign iaddr_o = sel ? iaddr1 : iaddr0;

  // Backing memory content: 0x100 -> 0xAAAA0001, 0x104 -> 0xAAAA0002, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[17:2] - 16'h003F;
    return {16'hAAAA, lo};
  endfunction

  // One fetch: expected fill addresses and data go to the scoreboard, memory answers
  // after wait_n busy cycles per word, and the hit pops/compares data and latency.
  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int wait_n);
    int cyc, lat, w;
    bit done;
    logic [31:0] base, exp_d;
    base = a & ~(32'(words * 4) - 32'd1);
    lat  = exp_hit ? 0 : words * (wait_n + 1) + 1;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    exp_data_q.push_back(mem_word(a));
    if (!exp_hit) for (int k = 0; k < words; k++) exp_addr_q.push_back(base + 32'(4 * k));
    cyc = 0; done = 1'b0; w = wait_n;
    while (!done && cyc < 200) begin
      #1;
      if (iren_o) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL fetch_iren %h: iREN=1 iaddr=%h, required iREN=0", a, iaddr_o);
        end else if (iaddr_o !== exp_addr_q[0]) begin
          n_bad++; $display("FAIL fetch_iaddr %h: got %h, required %h", a, iaddr_o, exp_addr_q[0]);
        end
        n_cmp++;
        if (ihit_o !== 1'b0) begin
          n_bad++; $display("FAIL fetch_hit_in_fill %h: got %b, required 0", a, ihit_o);
        end
        if (w > 0) begin
          iwait = 1'b1; w--;
        end else begin
          iwait = 1'b0;
          iload = (exp_addr_q.size() > 0) ? mem_word(exp_addr_q[0]) : 32'h0;
          if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
          w = wait_n;
        end
      end else begin
        iwait = 1'b1;
        if (ihit_o === 1'b1) begin
          done  = 1'b1;
          exp_d = exp_data_q.pop_front();
          n_cmp++;
          if (load_o !== exp_d) begin
            n_bad++; $display("FAIL fetch_data %h: got %h, required %h", a, load_o, exp_d);
          end
          n_cmp++;
          if (cyc !== lat) begin
            n_bad++; $display("FAIL fetch_latency %h: got %0d cycles, required %0d", a, cyc, lat);
          end
          n_cmp++;
          if (exp_addr_q.size() != 0) begin
            n_bad++; $display("FAIL fetch_fill_words %h: %0d words unfetched, required 0", a, exp_addr_q.size());
          end
        end
      end
      if (!done) begin
        @(negedge CLK);
        cyc++;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_timeout %h: no ihit after %0d cycles, required hit", a, cyc);
      exp_addr_q.delete();
      exp_data_q.delete();
    end
    imemREN = 1'b0;
    iwait   = 1'b1;
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    imemREN = 1'b1; imemaddr = 32'h100;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (ihit_o !== 1'b0) begin n_bad++; $display("FAIL reset_ihit: got %b, required 0", ihit_o); end
    n_cmp++; if (iren_o !== 1'b0) begin n_bad++; $display("FAIL reset_iren: got %b, required 0", iren_o); end
    n_cmp++; if (iaddr_o !== 32'h0) begin n_bad++; $display("FAIL reset_iaddr: got %h, required 0", iaddr_o); end
    n_cmp++; if (load_o !== 32'h0) begin n_bad++; $display("FAIL reset_imemload: got %h, required 0", load_o); end
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h100, 1'b0, 2);
    fetch(32'h104, 1'b1, 0);
  endtask

  task automatic test_round_robin();
    fetch(32'h180, 1'b0, 0);
    fetch(32'h100, 1'b1, 0);
    fetch(32'h200, 1'b0, 0);
    fetch(32'h180, 1'b1, 0);
    fetch(32'h100, 1'b0, 0);
  endtask

  task automatic test_addr_change();
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b0; #1;
    n_cmp++; if (iren_o !== 1'b0) begin n_bad++; $display("FAIL chg_idle_iren: got %b, required 0", iren_o); end
    @(negedge CLK); #1;
    n_cmp++; if (iaddr_o !== 32'h300) begin n_bad++; $display("FAIL chg_word0: got %h, required 00000300", iaddr_o); end
    iwait = 1'b0; iload = mem_word(32'h300);
    @(negedge CLK); imemaddr = 32'h400; #1;
    iwait = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (iaddr_o !== 32'h304) begin n_bad++; $display("FAIL chg_word1: got %h, required 00000304", iaddr_o); end
    n_cmp++; if (ihit_o !== 1'b0) begin n_bad++; $display("FAIL chg_hit_in_fill: got %b, required 0", ihit_o); end
    iwait = 1'b0; iload = mem_word(32'h304); imemREN = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (iren_o !== 1'b0) begin n_bad++; $display("FAIL chg_done_iren: got %b, required 0", iren_o); end
    iwait = 1'b1;
    fetch(32'h300, 1'b1, 0);
    fetch(32'h304, 1'b1, 0);
    fetch(32'h400, 1'b0, 0);
  endtask

  task automatic test_flush_mid_fill();
    fetch(32'h400, 1'b1, 0);
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h500; iwait = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (iaddr_o !== 32'h500) begin n_bad++; $display("FAIL flush_word0: got %h, required 00000500", iaddr_o); end
    iwait = 1'b0; iload = mem_word(32'h500);
    @(negedge CLK); #1;
    n_cmp++; if (iaddr_o !== 32'h504) begin n_bad++; $display("FAIL flush_word1: got %h, required 00000504", iaddr_o); end
    flush = 1'b1; imemREN = 1'b0; iwait = 1'b1;
    @(negedge CLK); #1;
    flush = 1'b0;
    n_cmp++; if (iren_o !== 1'b0) begin n_bad++; $display("FAIL flush_iren: got %b, required 0", iren_o); end
    n_cmp++; if (iaddr_o !== 32'h0) begin n_bad++; $display("FAIL flush_iaddr: got %h, required 0", iaddr_o); end
    fetch(32'h400, 1'b0, 0);
    fetch(32'h500, 1'b0, 0);
    // pointer untouched by the flush: the next replacement evicts way 0 (0x400)
    fetch(32'h300, 1'b0, 0);
    fetch(32'h500, 1'b1, 0);
    fetch(32'h400, 1'b0, 0);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h600; iwait = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (iren_o !== 1'b1) begin n_bad++; $display("FAIL rst_fill_iren: got %b, required 1", iren_o); end
    #1 nRST = 1'b0; imemaddr = 32'h400;
    #1;
    n_cmp++; if (iren_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_iren: got %b, required 0", iren_o); end
    n_cmp++; if (ihit_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_ihit: got %b, required 0", ihit_o); end
    n_cmp++; if (iaddr_o !== 32'h0) begin n_bad++; $display("FAIL rst_async_iaddr: got %h, required 0", iaddr_o); end
    @(negedge CLK); nRST = 1'b1; imemREN = 1'b0;
    fetch(32'h400, 1'b0, 0);
    fetch(32'h500, 1'b0, 0);
  endtask

  task automatic test_sweep();
    sel = 1'b1; words = 1;
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    fetch(32'h0,  1'b0, 1);
    fetch(32'h10, 1'b0, 1);
    fetch(32'h0,  1'b0, 0);
    fetch(32'h10, 1'b0, 0);
    fetch(32'h10, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_round_robin();
    test_addr_change();
    test_flush_mid_fill();
    test_reset_mid_fill();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
